// File: rtl/pulse_width_detector.sv
// Multi-channel pulse width detector with per-channel polarity.
// Flags in-range pulses, over-long pulses, edges and measured run length.
module pulse_width_detector #(
  parameter int N_CH    = 4,
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 1,
  parameter int CNT_W   = $clog2(MAX_LEN + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       pol,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH-1:0]       detected,
  output logic [N_CH-1:0]       too_long,
  output logic [N_CH*CNT_W-1:0] last_len,
  output logic [N_CH-1:0]       len_valid,
  output logic                  any_detected
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(MAX_LEN);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] len_q;
    logic             pol_q;
    logic             lv_q;
    logic             act;
    logic             ok;

    assign act = a[i] ^ pol[i];
    assign ok  = (pol[i] == pol_q);

    // A polarity change discards the current run.
    always_comb begin
      cnt_nxt = '0;
      if (ok && act) begin
        cnt_nxt = (cnt == SAT) ? cnt : cnt + CNT_W'(1);
      end
    end

    assign rise[i]     = ok & act & (cnt == '0);
    assign fall[i]     = ok & ~act & (cnt != '0);
    assign detected[i] = fall[i] & (cnt >= LO) & (cnt <= HI);
    assign too_long[i] = fall[i] & (cnt == SAT);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt   <= '0;
        pol_q <= 1'b0;
        len_q <= '0;
        lv_q  <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        pol_q <= pol[i];
        lv_q  <= fall[i];
        if (fall[i]) begin
          len_q <= cnt;
        end
      end
    end

    assign last_len[i*CNT_W +: CNT_W] = len_q;
    assign len_valid[i]               = lv_q;
  end

  assign any_detected = |detected;

endmodule

// File: tb/tb_pulse_width_detector.sv
// Scoreboard bench for pulse_width_detector (MIN_LEN=2, MAX_LEN=3).
// Directed scenarios followed by random traffic against a run-length model.
module tb_pulse_width_detector;

  localparam int NC  = 4;
  localparam int MN  = 2;
  localparam int MX  = 3;
  localparam int CW  = $clog2(MX + 2);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC-1:0]   a   = '0;
  logic [NC-1:0]   pol = '0;
  logic [NC-1:0]   rise, fall, detected, too_long, len_valid;
  logic [NC*CW-1:0] last_len;
  logic            any_detected;

  pulse_width_detector #(
    .N_CH(NC), .MIN_LEN(MN), .MAX_LEN(MX)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .pol(pol),
    .rise(rise), .fall(fall), .detected(detected),
    .too_long(too_long), .last_len(last_len),
    .len_valid(len_valid), .any_detected(any_detected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [NC-1:0]    rise, fall, det, tl, lv;
    logic [NC*CW-1:0] ll;
    logic             any;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: unbounded run length, clipped only when reported.
  int   m_run [NC];
  int   m_ll  [NC];
  bit   m_lv  [NC];
  bit   m_pol [NC];

  task automatic chk(input string nm, input int c,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [NC-1:0] av,
                       input logic [NC-1:0] pv);
    exp_t e;
    bit   act [NC];
    bit   ok  [NC];
    @(posedge clk);
    #1;
    rst = r;
    a   = av;
    pol = pv;
    cyc++;
    e.cyc = cyc;
    for (int i = 0; i < NC; i++) begin
      act[i]    = av[i] ^ pv[i];
      ok[i]     = (pv[i] == m_pol[i]);
      e.rise[i] = ok[i] && act[i] && m_run[i] == 0;
      e.fall[i] = ok[i] && !act[i] && m_run[i] > 0;
      e.det[i]  = e.fall[i] && m_run[i] >= MN && m_run[i] <= MX;
      e.tl[i]   = e.fall[i] && m_run[i] > MX;
      e.lv[i]   = m_lv[i];
      e.ll[i*CW +: CW] = CW'(m_ll[i]);
    end
    e.any = |e.det;
    sb.push_back(e);
    for (int i = 0; i < NC; i++) begin
      if (r) begin
        m_run[i] = 0; m_pol[i] = 0; m_ll[i] = 0; m_lv[i] = 0;
      end else begin
        m_lv[i] = e.fall[i];
        if (e.fall[i]) m_ll[i] = (m_run[i] > MX) ? MX + 1 : m_run[i];
        m_run[i] = (ok[i] && act[i]) ? m_run[i] + 1 : 0;
        m_pol[i] = pv[i];
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rise",     e.cyc, 32'(rise),         32'(e.rise));
        chk("fall",     e.cyc, 32'(fall),         32'(e.fall));
        chk("detected", e.cyc, 32'(detected),     32'(e.det));
        chk("too_long", e.cyc, 32'(too_long),     32'(e.tl));
        chk("len_vld",  e.cyc, 32'(len_valid),    32'(e.lv));
        chk("last_len", e.cyc, 32'(last_len),     32'(e.ll));
        chk("any_det",  e.cyc, 32'(any_detected), 32'(e.any));
      end
    end
  end

  task automatic run_ch(input int ch, input int len, input logic [NC-1:0] pv);
    logic [NC-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    for (int k = 0; k < len; k++) cycle(1'b0, v ^ pv, pv);
    cycle(1'b0, pv, pv);
  endtask

  initial begin : stim
    logic [NC-1:0] av, pv;
    int            wait_n;
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0; m_ll[i] = 0; m_lv[i] = 0; m_pol[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // reset state, then runs of 1..4 on ch1, then a long run on ch0
    cycle(1'b0, 4'b0000, 4'b0000);
    for (int l = 1; l <= 4; l++) run_ch(1, l, 4'b0000);
    run_ch(0, 10, 4'b0000);
    // ch2 low pulse with pol=1; ch3 same waveform with pol=0
    cycle(1'b0, 4'b1100, 4'b0100);
    cycle(1'b0, 4'b1100, 4'b0100);
    cycle(1'b0, 4'b0000, 4'b0100);
    cycle(1'b0, 4'b0000, 4'b0100);
    cycle(1'b0, 4'b1100, 4'b0100);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    // pol[1] flips mid-run, then a clean pulse
    cycle(1'b0, 4'b0010, 4'b0000);
    cycle(1'b0, 4'b0010, 4'b0010);
    cycle(1'b0, 4'b1101, 4'b0010);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    run_ch(1, 2, 4'b0000);
    // reset during a high run on all channels
    cycle(1'b0, 4'b1111, 4'b0000);
    cycle(1'b0, 4'b1111, 4'b0000);
    cycle(1'b1, 4'b1111, 4'b0000);
    cycle(1'b0, 4'b1111, 4'b0000);
    cycle(1'b0, 4'b1111, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0000, 4'b0000);
    // random traffic
    av = '0;
    pv = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(2) == 0) av[i] = ~av[i];
      end
      if ($urandom_range(63) == 0) pv[$urandom_range(NC-1)] ^= 1'b1;
      cycle($urandom_range(199) == 0, av, pv);
    end
    cycle(1'b0, pv, pv);
    wait_n = 0;
    while (sb.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
